uart_tx_framer: RTL and testbench
=================================

Name: uart_tx_framer

Overview:
Serial transmit framer that sits directly downstream of the bit-clock generator. It drives the generator's enable and consumes its toggling bit clock, treating every toggle as one bit boundary. It accepts a parallel byte via a valid/ready handshake and shifts out an async serial frame: start bit, DATA_BITS data bits LSB first, optional parity bit, STOP_BITS stop bits. Line idles high.

Parameters:
DATA_BITS, 8, payload width per frame (5..9)
STOP_BITS, 1, number of stop bits (1 or 2)
CLK_PER_BIT, 200, generator toggle period in clk cycles; documentation/bench only, not used in logic

Ports:
clk  input  1  system clock; single clock domain
rst  input  1  synchronous reset, active-high
tx_data  input  DATA_BITS  payload, sampled on accept
tx_valid  input  1  payload valid
tx_ready  output  1  framer idle and able to accept
bit_clk  input  1  toggling bit clock from the generator (same clk domain)
bit_clk_en  output  1  enable to the generator; high while a frame is in flight
tx_out  output  1  serial line
busy  output  1  frame in progress (equals ~tx_ready)

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, tx_out=1, bit_clk_en=0, tx_ready=1, busy=0, shift register=0, bit counter=0, bit_clk_d loads bit_clk. No false tick after reset.
- Tick detect: register bit_clk_d <= bit_clk every cycle; tick = bit_clk ^ bit_clk_d (combinational). Both edges count. Ticks are ignored in IDLE.
- Accept: in IDLE, tx_valid & tx_ready at an edge latches tx_data and moves to START. Acceptance happens only in IDLE.
- States and transitions:
  - IDLE: tx_out=1, bit_clk_en=0. On accept, go to START.
  - START: tx_out=0, bit_clk_en=1. On tick, go to DATA with bit counter=0.
  - DATA: tx_out=shift[0]. On tick, shift right and increment the counter. After DATA_BITS ticks, go to PARITY (feature on) or STOP.
  - PARITY: tx_out=parity bit. On tick, go to STOP.
  - STOP: tx_out=1. After STOP_BITS ticks, go to IDLE and drop bit_clk_en.
- Registered outputs: tx_out, bit_clk_en and tx_ready all take effect on the clk edge of the state change.
- Timing:
  - The generator restarts its count when enabled, so the start bit lasts CLK_PER_BIT+1 clk cycles.
  - Every later bit lasts exactly CLK_PER_BIT cycles.
  - Frame length = (1+DATA_BITS+P+STOP_BITS)*CLK_PER_BIT + 1 cycles, where P = 1 if parity is enabled, else 0.
- Back-to-back: at least one IDLE cycle separates frames. tx_ready rises the cycle after the final stop tick; a held tx_valid is accepted on that IDLE cycle.
- Input stability: tx_data changes while busy have no effect. tx_valid while busy is ignored, not queued.
- Reset mid-frame: abort immediately. tx_out=1 and bit_clk_en=0 on the next edge. A partial frame is acceptable.
- The bit counter width is clog2(DATA_BITS+1). Counting never wraps because state exits at terminal count.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted after DATA and transmits the even-parity bit (XOR of the latched payload), computed at accept time and held in a register.
- Undefined: no PARITY state, no parity register; DATA goes directly to STOP.

Decomposition:
- Shared package uart_pkg:
  - state encoding typedef (IDLE, START, DATA, PARITY, STOP)
  - LINE_IDLE=1'b1, START_LVL=1'b0, STOP_LVL=1'b1
  - function for counter width
- Sub-module edge_toggle_detect holds bit_clk_d and produces tick; its reset-load rule is as above.
- All other logic stays flat in uart_tx_framer.

Test Plan:
- Single byte: CLK_PER_BIT=4 (bench-instantiated generator), tx_data=8'hA5, one-cycle tx_valid. Expect tx_out = 0 for 5 cycles, then 1,0,1,0,0,1,0,1 at 4 cycles each, then 1 for 4 cycles. tx_ready returns after 41 cycles total.
- Back-to-back: tx_valid held high with 8'h00 then 8'hFF. Expect exactly one IDLE cycle (tx_out=1, bit_clk_en=0) between frames; second frame data bits all 1.
- Busy ignore: pulse tx_valid with 8'h3C mid-frame of 8'h81. Expect serial payload 8'h81 only and no second frame.
- Reset mid-frame: assert rst during DATA bit 3. Expect tx_out=1, bit_clk_en=0, tx_ready=1 the next cycle, and no tick-driven activity afterward. A new byte 8'h55 then sends cleanly.
- Parity (UART_TX_PARITY_EN): 8'h07 gives parity bit 1; 8'h03 gives 0. Frame is 11 bits, 45 cycles at CLK_PER_BIT=4.
- STOP_BITS=2: 8'hC3 gives a stop level of 8 cycles before tx_ready rises.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit framer.
// State encoding, line levels and counter sizing.
package uart_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_START  = 3'd1;
  localparam state_t S_DATA   = 3'd2;
  localparam state_t S_PARITY = 3'd3;
  localparam state_t S_STOP   = 3'd4;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/edge_toggle_detect.sv
// Turns each toggle of the generator bit clock into a one-cycle tick.
// Reset loads the current level so no false tick follows reset.
module edge_toggle_detect (
  input  logic clk,
  input  logic rst,
  input  logic bit_clk,
  output logic tick
);

  logic bit_clk_d;

  always_ff @(posedge clk) begin
    if (rst) bit_clk_d <= bit_clk;
    else     bit_clk_d <= bit_clk;
  end

  assign tick = bit_clk ^ bit_clk_d;

endmodule

// File: rtl/uart_tx_framer.sv
// Async serial transmit framer driven by an external bit-clock generator.
// Optional even parity bit when UART_TX_PARITY_EN is defined.
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int STOP_BITS   = 1,
  parameter int CLK_PER_BIT = 200
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic                 bit_clk,
  output logic                 bit_clk_en,
  output logic                 tx_out,
  output logic                 busy
);

  localparam int CW = cnt_width(DATA_BITS);

  if (DATA_BITS < 5 || DATA_BITS > 9 ||
      STOP_BITS < 1 || STOP_BITS > 2 ||
      CLK_PER_BIT < 1) begin : g_cfg_err
    $error("uart_tx_framer: bad parameters");
  end

  state_t               state, state_nxt;
  logic [DATA_BITS-1:0] shift, shift_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic                 tick;
  logic                 tx_out_nxt;

`ifdef UART_TX_PARITY_EN
  logic par, par_nxt;
`endif

  edge_toggle_detect u_tick (
    .clk     (clk),
    .rst     (rst),
    .bit_clk (bit_clk),
    .tick    (tick)
  );

  always_comb begin
    state_nxt = state;
    shift_nxt = shift;
    cnt_nxt   = cnt;
`ifdef UART_TX_PARITY_EN
    par_nxt   = par;
`endif
    unique case (state)
      S_IDLE: begin
        if (tx_valid) begin
          state_nxt = S_START;
          shift_nxt = tx_data;
`ifdef UART_TX_PARITY_EN
          par_nxt   = ^tx_data;
`endif
        end
      end
      S_START: begin
        if (tick) begin
          state_nxt = S_DATA;
          cnt_nxt   = '0;
        end
      end
      S_DATA: begin
        if (tick) begin
          shift_nxt = shift >> 1;
          if (cnt == CW'(DATA_BITS - 1)) begin
            cnt_nxt = '0;
`ifdef UART_TX_PARITY_EN
            state_nxt = S_PARITY;
`else
            state_nxt = S_STOP;
`endif
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (tick) begin
          state_nxt = S_STOP;
          cnt_nxt   = '0;
        end
      end
`endif
      S_STOP: begin
        if (tick) begin
          if (cnt == CW'(STOP_BITS - 1)) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Line level is registered from the next state so it switches with it
  always_comb begin
    tx_out_nxt = LINE_IDLE;
    unique case (state_nxt)
      S_START:  tx_out_nxt = START_LVL;
      S_DATA:   tx_out_nxt = shift_nxt[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_out_nxt = par_nxt;
`endif
      S_STOP:   tx_out_nxt = STOP_LVL;
      default:  tx_out_nxt = LINE_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      shift      <= '0;
      cnt        <= '0;
      tx_out     <= LINE_IDLE;
      bit_clk_en <= 1'b0;
      tx_ready   <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par        <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      shift      <= shift_nxt;
      cnt        <= cnt_nxt;
      tx_out     <= tx_out_nxt;
      bit_clk_en <= (state_nxt != S_IDLE);
      tx_ready   <= (state_nxt == S_IDLE);
`ifdef UART_TX_PARITY_EN
      par        <= par_nxt;
`endif
    end
  end

  assign busy = ~tx_ready;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench for uart_tx_framer with a 4-cycle bit-clock generator.
// Second instance covers two stop bits.
module tb_uart_tx_framer;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready, bit_clk_en, tx_out, busy;
  logic       bit_clk = 1'b0;
  int         gcnt = 0;

  logic [7:0] tx_data2 = '0;
  logic       tx_valid2 = 1'b0;
  logic       tx_ready2, bit_clk_en2, tx_out2, busy2;
  logic       bit_clk2 = 1'b0;
  int         gcnt2 = 0;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  uart_tx_framer #(.DATA_BITS(8), .STOP_BITS(1), .CLK_PER_BIT(CPB)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .bit_clk    (bit_clk),
    .bit_clk_en (bit_clk_en),
    .tx_out     (tx_out),
    .busy       (busy)
  );

  uart_tx_framer #(.DATA_BITS(8), .STOP_BITS(2), .CLK_PER_BIT(CPB)) u_dut2 (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (tx_data2),
    .tx_valid   (tx_valid2),
    .tx_ready   (tx_ready2),
    .bit_clk    (bit_clk2),
    .bit_clk_en (bit_clk_en2),
    .tx_out     (tx_out2),
    .busy       (busy2)
  );

  // Generator: count restarts while disabled, toggle every CPB cycles
  always @(posedge clk) begin
    if (rst || !bit_clk_en) gcnt <= 0;
    else if (gcnt == CPB - 1) begin
      gcnt <= 0;
      bit_clk <= ~bit_clk;
    end else gcnt <= gcnt + 1;
  end

  always @(posedge clk) begin
    if (rst || !bit_clk_en2) gcnt2 <= 0;
    else if (gcnt2 == CPB - 1) begin
      gcnt2 <= 0;
      bit_clk2 <= ~bit_clk2;
    end else gcnt2 <= gcnt2 + 1;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit sel, input logic v, input logic [7:0] d);
    if (sel) begin
      tx_valid2 = v;
      tx_data2  = d;
    end else begin
      tx_valid = v;
      tx_data  = d;
    end
  endtask

  function automatic logic obs_line(input bit sel);
    return sel ? tx_out2 : tx_out;
  endfunction
  function automatic logic obs_rdy(input bit sel);
    return sel ? tx_ready2 : tx_ready;
  endfunction
  function automatic logic obs_en(input bit sel);
    return sel ? bit_clk_en2 : bit_clk_en;
  endfunction
  function automatic logic obs_busy(input bit sel);
    return sel ? busy2 : busy;
  endfunction

  // j counts cycles after the accepting edge
  function automatic logic exp_line(input logic [7:0] d, input int j);
    if (j < CPB + 1)                return 1'b0;
    if (j < CPB + 1 + 8 * CPB)      return d[(j - CPB - 1) / CPB];
    if (P == 1 && j < CPB + 1 + 9 * CPB) return ^d;
    return 1'b1;
  endfunction

  task automatic run_frame(input bit sel, input logic [7:0] d,
                           input bit hold, input bit inj);
    int sb;
    int len;
    sb  = sel ? 2 : 1;
    len = (1 + 8 + P + sb) * CPB + 1;
    check("ready_pre", obs_rdy(sel), 1'b1);
    drive(sel, 1'b1, d);
    step();
    if (!hold) drive(sel, 1'b0, d);
    for (int j = 0; j <= len; j++) begin
      check($sformatf("line d=%0h j=%0d", d, j), obs_line(sel), exp_line(d, j));
      check($sformatf("ready d=%0h j=%0d", d, j), obs_rdy(sel), j >= len);
      check($sformatf("en d=%0h j=%0d", d, j), obs_en(sel), j < len);
      check($sformatf("busy d=%0h j=%0d", d, j), obs_busy(sel), j < len);
      if (inj && j == 10) drive(sel, 1'b1, 8'h3C);
      if (inj && j == 11) drive(sel, 1'b0, 8'h3C);
      if (j < len) step();
    end
  endtask

  task automatic idle_hold(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      step();
      check($sformatf("%s line %0d", tag, i), tx_out, 1'b1);
      check($sformatf("%s ready %0d", tag, i), tx_ready, 1'b1);
      check($sformatf("%s en %0d", tag, i), bit_clk_en, 1'b0);
    end
  endtask

  initial begin
    repeat (3) step();
    check("rst_line", tx_out, 1'b1);
    check("rst_en", bit_clk_en, 1'b0);
    check("rst_ready", tx_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_line2", tx_out2, 1'b1);
    check("rst_ready2", tx_ready2, 1'b1);
    rst = 1'b0;
    step();

    // Single byte, one-cycle valid
    run_frame(1'b0, 8'hA5, 1'b0, 1'b0);
    idle_hold(3, "after_a5");

    // Back-to-back with valid held: one idle cycle between frames
    run_frame(1'b0, 8'h00, 1'b1, 1'b0);
    run_frame(1'b0, 8'hFF, 1'b0, 1'b0);
    idle_hold(3, "after_b2b");

    // Valid pulse and data change while busy are ignored
    run_frame(1'b0, 8'h81, 1'b0, 1'b1);
    idle_hold(10, "no_second");

    // Reset during data bit 3
    drive(1'b0, 1'b1, 8'h96);
    step();
    drive(1'b0, 1'b0, 8'h96);
    for (int j = 0; j < CPB + 1 + 3 * CPB + 1; j++) step();
    check("pre_rst_line", tx_out, 1'b1 ^ 1'b0 ^ exp_line(8'h96, 18) ^ 1'b1);
    rst = 1'b1;
    step();
    check("mid_rst_line", tx_out, 1'b1);
    check("mid_rst_en", bit_clk_en, 1'b0);
    check("mid_rst_ready", tx_ready, 1'b1);
    check("mid_rst_busy", busy, 1'b0);
    rst = 1'b0;
    idle_hold(12, "post_rst");
    run_frame(1'b0, 8'h55, 1'b0, 1'b0);

`ifdef UART_TX_PARITY_EN
    run_frame(1'b0, 8'h07, 1'b0, 1'b0);
    run_frame(1'b0, 8'h03, 1'b0, 1'b0);
`endif

    // Two stop bits on the second instance
    run_frame(1'b1, 8'hC3, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
